shift_ser_ctrl: RTL
===================

// Module: shift_ser_ctrl
// PURPOSE
//  Sequencer and arbiter for one 8-bit shift_reg datapath, shared between a TX
//  client (parallel-in/serial-out) and an RX client (serial-in/parallel-out).
//  Drives the shift_reg mode, parallel and serial inputs, and divides clk into bit periods.
//  Round-robin grant between the TX and RX clients; one frame in flight at a time.
// PARAMETERS
//  CLKDIV     4   clk cycles per serial bit; range 1..256
//  MSB_FIRST  1   1: shift LEFT, MSB first; 0: shift RIGHT, LSB first
// PORTS
//  clk         in   1  system clock
//  nrst        in   1  synchronous, active-low reset
//  tx_valid_i  in   1  TX word offered; must be held until tx_ready_o is seen
//  tx_data_i   in   8  TX word
//  tx_ready_o  out  1  TX handshake accept
//  sdo_o       out  1  serial data out
//  rx_req_i    in   1  RX frame request (level)
//  rx_gnt_o    out  1  1-cycle pulse: RX frame started
//  sdi_i       in   1  serial data in
//  rx_valid_o  out  1  received word available
//  rx_data_o   out  8  received word; stable while rx_valid_o is 1
//  rx_ready_i  in   1  RX consumer accept
//  busy_o      out  1  state != IDLE
// BEHAVIOUR
//  States: IDLE, TX_SHIFT, RX_SHIFT, RX_DONE. Counters: div_cnt 0..CLKDIV-1, bit_cnt 0..7.
//  shift_reg mode encoding: HOLD=00, LOAD=01, LEFT=10, RIGHT=11.
//  SHIFT below means LEFT if MSB_FIRST=1, else RIGHT.
//  Default shift_reg mode is HOLD in every state/cycle not listed.
//  IDLE:
//   - Arbitration among tx_valid_i and rx_req_i.
//   - If both are requesting, grant the client not granted last (last_gnt flop).
//   - TX win: tx_ready_o=1, mode=LOAD, par_i=tx_data_i, go TX_SHIFT.
//   - RX win: rx_gnt_o=1, go RX_SHIFT.
//   - Both win paths clear div_cnt and bit_cnt.
//   - tx_ready_o is combinational; it is 1 only in IDLE when TX wins.
//  TX_SHIFT:
//   - sdo_o = P[7] (MSB_FIRST) or P[0]; shift_reg D input = 0.
//   - At div_cnt==CLKDIV-1: mode=SHIFT, bit_cnt++. At bit_cnt==7 (the last shift): go IDLE.
//  RX_SHIFT:
//   - At div_cnt==CLKDIV-1: mode=SHIFT with D=sdi_i (sample taken at end of the bit period).
//   - At bit_cnt==7: go RX_DONE.
//  RX_DONE: rx_valid_o=1, rx_data_o=P, mode HOLD. On rx_ready_i=1 go IDLE.
//   - TX requests are blocked while in RX_DONE.
//  sdo_o = 1 whenever the state is not TX_SHIFT.
//  Latency:
//   - TX: handshake in cycle H; IDLE again in cycle H+1+8*CLKDIV.
//   - TX: bit k is driven on sdo_o during cycles H+1+k*CLKDIV .. H+(k+1)*CLKDIV.
//   - RX: grant in cycle G; rx_valid_o=1 from cycle G+1+8*CLKDIV.
//   - Back-to-back: a new grant is possible in the first IDLE cycle.
//  Reset (any state, including mid-frame):
//   - state=IDLE, counters=0, P=0.
//   - last_gnt=RX, so TX wins the first tie.
//   - Outputs: tx_ready_o=0, rx_gnt_o=0, rx_valid_o=0, rx_data_o=0, sdo_o=1, busy_o=0.
//   - A partial frame is discarded; the TX word must be re-offered.
//  Boundary cases:
//   - CLKDIV=1: one shift per cycle.
//   - A request dropped before it is granted is ignored.
//   - rx_req_i held high re-requests after RX_DONE; round-robin gives TX the next turn.
// STRUCTURE
//  shift_pkg: mode_t enum (HOLD/LOAD/LEFT/RIGHT), state_t enum.
//  Sub-module: exactly one shift_reg instance (clk, nrst, D, mode_i, par_i, P).
//  This block holds the FSM, div_cnt, bit_cnt and last_gnt, plus combinational output decode.
// TESTING (CLKDIV=4 unless noted)
//  1. TX 8'hA5, MSB_FIRST=1 -> sdo_o=1,0,1,0,0,1,0,1, each bit held 4 cycles;
//     busy_o high for 32 cycles.
//  2. RX with sdi_i driving 8'h3C MSB-first, rx_ready_i=1 -> rx_valid_o at G+33,
//     rx_data_o=8'h3C for 1 cycle.
//  3. tx_valid_i and rx_req_i both held high after reset -> TX frame first, then RX grant,
//     then TX again (alternating grants).
//  4. rx_ready_i=0 for 10 cycles with tx_valid_i=1 -> rx_valid_o and rx_data_o held;
//     tx_ready_o stays 0 until after the accept.
//  5. nrst=0 at bit 3 of a TX frame -> next cycle IDLE, sdo_o=1, busy_o=0;
//     re-offered word transmits in full.
//  6. MSB_FIRST=0, CLKDIV=1, TX 8'h0F -> sdo_o=1,1,1,1,0,0,0,0 on consecutive cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the shift_ser_ctrl sequencer and its shift_reg datapath.
package shift_pkg;
  localparam int W = 8;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LOAD  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    TX_SHIFT,
    RX_SHIFT,
    RX_DONE
  } state_t;

  typedef enum logic {
    GNT_TX = 1'b0,
    GNT_RX = 1'b1
  } gnt_t;
endpackage

// File: rtl/shift_reg.sv
// 8-bit shift register: hold, parallel load, or shift with serial input D.
module shift_reg
  import shift_pkg::*;
(
  input  logic         clk,
  input  logic         nrst,
  input  logic         D,
  input  mode_t        mode_i,
  input  logic [W-1:0] par_i,
  output logic [W-1:0] P
);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      P <= '0;
    end else begin
      case (mode_i)
        LOAD:    P <= par_i;
        LEFT:    P <= {P[W-2:0], D};
        RIGHT:   P <= {D, P[W-1:1]};
        default: P <= P;
      endcase
    end
  end

endmodule

// File: rtl/shift_ser_ctrl.sv
// Arbitrates one shift_reg between a TX (PISO) and an RX (SIPO) client, one frame at a time.
module shift_ser_ctrl
  import shift_pkg::*;
#(
  parameter int CLKDIV    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         tx_valid_i,
  input  logic [W-1:0] tx_data_i,
  output logic         tx_ready_o,
  output logic         sdo_o,
  input  logic         rx_req_i,
  output logic         rx_gnt_o,
  input  logic         sdi_i,
  output logic         rx_valid_o,
  output logic [W-1:0] rx_data_o,
  input  logic         rx_ready_i,
  output logic         busy_o
);

  localparam int              DIVW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIVW-1:0] DIV_MAX = DIVW'(CLKDIV - 1);
  localparam mode_t           SHIFT   = MSB_FIRST ? LEFT : RIGHT;

  state_t          state, state_n;
  logic [DIVW-1:0] div_cnt;
  logic [2:0]      bit_cnt;
  gnt_t            last_gnt;

  logic            tick, clr, tx_win, rx_win, d;
  mode_t           mode;
  logic [W-1:0]    par, p;

  shift_reg u_sreg (
    .clk    (clk),
    .nrst   (nrst),
    .D      (d),
    .mode_i (mode),
    .par_i  (par),
    .P      (p)
  );

  assign tick   = (div_cnt == DIV_MAX);
  // On a tie the client not served last wins.
  assign tx_win = tx_valid_i && (!rx_req_i || last_gnt == GNT_RX);
  assign rx_win = rx_req_i && (!tx_valid_i || last_gnt == GNT_TX);
  assign busy_o = (state != IDLE);

  always_comb begin
    state_n    = state;
    mode       = HOLD;
    par        = '0;
    d          = 1'b0;
    clr        = 1'b0;
    tx_ready_o = 1'b0;
    rx_gnt_o   = 1'b0;
    rx_valid_o = 1'b0;
    rx_data_o  = '0;
    sdo_o      = 1'b1;
    case (state)
      IDLE: begin
        if (tx_win) begin
          tx_ready_o = 1'b1;
          mode       = LOAD;
          par        = tx_data_i;
          clr        = 1'b1;
          state_n    = TX_SHIFT;
        end else if (rx_win) begin
          rx_gnt_o   = 1'b1;
          clr        = 1'b1;
          state_n    = RX_SHIFT;
        end
      end
      TX_SHIFT: begin
        sdo_o = MSB_FIRST ? p[W-1] : p[0];
        if (tick) begin
          mode = SHIFT;
          if (bit_cnt == 3'd7) state_n = IDLE;
        end
      end
      RX_SHIFT: begin
        // Sample at the end of the bit period.
        if (tick) begin
          mode = SHIFT;
          d    = sdi_i;
          if (bit_cnt == 3'd7) state_n = RX_DONE;
        end
      end
      RX_DONE: begin
        rx_valid_o = 1'b1;
        rx_data_o  = p;
        if (rx_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      last_gnt <= GNT_RX;
    end else begin
      state <= state_n;
      if (clr) begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (state == TX_SHIFT || state == RX_SHIFT) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) bit_cnt <= bit_cnt + 3'd1;
      end
      if (tx_ready_o)    last_gnt <= GNT_TX;
      else if (rx_gnt_o) last_gnt <= GNT_RX;
    end
  end

endmodule
